// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame driver.
// Contents: FSM state encoding, frame widths for the raybox-zero vector
// port and register port.
package spi_frame_pkg;

   localparam int unsigned FRAME_W_VEC = 74;
   localparam int unsigned FRAME_W_REG = 14;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEAD = 3'd1,
      ST_HIGH = 3'd2,
      ST_LOW  = 3'd3,
      ST_TAIL = 3'd4,
      ST_GAP  = 3'd5
   } state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// SCLK half-period down-counter.
// Ports: clk, reset (async, active-high), i_load (reload HALF-1),
//        o_expired_c (counter at zero: current phase ends this cycle).
module spi_phase_timer #(
   parameter int unsigned HALF = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   output logic o_expired_c
);

   localparam int unsigned TICK_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [TICK_W-1:0] r_tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tick <= '0;
      end else if (i_load) begin
         r_tick <= TICK_W'(HALF - 1);
      end else if (r_tick != '0) begin
         r_tick <= r_tick - TICK_W'(1);
      end
   end

   assign o_expired_c = (r_tick == '0);

endmodule

// File: rtl/spi_frame_driver.sv
// Serialises a right-justified parallel frame into one SPI mode-0
// transaction (MSB of the frame first).
// Ports: clk, reset (async, active-high); i_start/i_len/i_data request a
//        frame, i_abort ends it at once; o_busy, o_done (one-cycle pulse on
//        normal completion), o_csb/o_sclk/o_mosi SPI pins. All outputs are
//        registered.
module spi_frame_driver
   import spi_frame_pkg::*;
#(
   parameter int unsigned FRAME_W = FRAME_W_VEC,
   parameter int unsigned HALF    = 2,
   parameter int unsigned LEN_W   = $clog2(FRAME_W + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   input  logic [LEN_W-1:0]   i_len,
   input  logic [FRAME_W-1:0] i_data,
   input  logic               i_abort,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_csb,
   output logic               o_sclk,
   output logic               o_mosi
);

   state_t             r_state;
   // Bits still to be sent after the one currently on MOSI, MSB next.
   logic [FRAME_W-2:0] r_shreg;
   logic [LEN_W-1:0]   r_bits;
   logic               r_busy;
   logic               r_done;
   logic               r_csb;
   logic               r_sclk;
   logic               r_mosi;

   logic               w_len_ok;
   logic               w_accept;
   logic               w_abort;
   logic               w_expired;
   logic               w_advance;
   logic               w_load;
   logic [LEN_W-1:0]   w_lsh;
   logic [FRAME_W-1:0] w_aligned;

   assign w_len_ok  = (i_len != '0) && (i_len <= LEN_W'(FRAME_W));
   assign w_accept  = (r_state == ST_IDLE) && i_start && !i_abort && w_len_ok;
   assign w_abort   = (r_state != ST_IDLE) && i_abort;
   assign w_advance = (r_state != ST_IDLE) && w_expired && !i_abort;
   assign w_load    = w_accept || w_advance;

   // Left-align the payload so i_data[i_len-1] lands on the MSB.
   assign w_lsh     = LEN_W'(FRAME_W) - i_len;
   assign w_aligned = i_data << w_lsh;

   spi_phase_timer #(
      .HALF (HALF)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .o_expired_c (w_expired)
   );

   // Phase sequencer; outputs are set together with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_bits  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_csb   <= 1'b1;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_csb   <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_state <= ST_LEAD;
                     r_shreg <= w_aligned[FRAME_W-2:0];
                     r_bits  <= i_len;
                     r_busy  <= 1'b1;
                     r_csb   <= 1'b0;
                     r_sclk  <= 1'b0;
                     r_mosi  <= w_aligned[FRAME_W-1];
                  end
               end
               ST_LEAD: begin
                  if (w_expired) begin
                     r_state <= ST_HIGH;
                     r_sclk  <= 1'b1;
                  end
               end
               ST_HIGH: begin
                  if (w_expired) begin
                     r_bits <= r_bits - LEN_W'(1);
                     r_sclk <= 1'b0;
                     if (r_bits != LEN_W'(1)) begin
                        // Next bit goes out on the falling edge.
                        r_state <= ST_LOW;
                        r_mosi  <= r_shreg[FRAME_W-2];
                        r_shreg <= {r_shreg[FRAME_W-3:0], 1'b0};
                     end else begin
                        r_state <= ST_TAIL;
                     end
                  end
               end
               ST_LOW: begin
                  if (w_expired) begin
                     r_state <= ST_HIGH;
                     r_sclk  <= 1'b1;
                  end
               end
               ST_TAIL: begin
                  if (w_expired) begin
                     r_state <= ST_GAP;
                     r_csb   <= 1'b1;
                     r_mosi  <= 1'b0;
                  end
               end
               ST_GAP: begin
                  if (w_expired) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_csb   <= 1'b1;
                  r_sclk  <= 1'b0;
                  r_mosi  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_csb  = r_csb;
   assign o_sclk = r_sclk;
   assign o_mosi = r_mosi;

endmodule

// File: tb/tb_spi_frame_driver.sv
// Bench for spi_frame_driver: one instance with HALF=1 (index 0) and one
// with HALF=2 (index 1), both FRAME_W=74. Output vectors are packed as
// {csb, sclk, mosi, busy, done}.
module tb_spi_frame_driver;

   localparam int FW = 74;

   logic        clk = 1'b0;
   logic        reset;
   logic        st [2];
   logic        ab [2];
   logic [6:0]  ln [2];
   logic [73:0] dt [2];

   logic d0_busy, d0_done, d0_csb, d0_sclk, d0_mosi;
   logic d1_busy, d1_done, d1_csb, d1_sclk, d1_mosi;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          d;
      int          len;
      logic [73:0] data;
      bit          ok;
   } vec_t;

   vec_t tbl [10];

   always #5 clk = ~clk;

   spi_frame_driver #(.FRAME_W(74), .HALF(1)) dut0 (
      .clk(clk), .reset(reset), .i_start(st[0]), .i_len(ln[0]), .i_data(dt[0]),
      .i_abort(ab[0]), .o_busy(d0_busy), .o_done(d0_done), .o_csb(d0_csb),
      .o_sclk(d0_sclk), .o_mosi(d0_mosi));

   spi_frame_driver #(.FRAME_W(74), .HALF(2)) dut1 (
      .clk(clk), .reset(reset), .i_start(st[1]), .i_len(ln[1]), .i_data(dt[1]),
      .i_abort(ab[1]), .o_busy(d1_busy), .o_done(d1_done), .o_csb(d1_csb),
      .o_sclk(d1_sclk), .o_mosi(d1_mosi));

   localparam logic [4:0] IDLE_OUT = 5'b10000;

   function automatic int half_of(int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic logic [4:0] get_out(int d);
      if (d == 0) return {d0_csb, d0_sclk, d0_mosi, d0_busy, d0_done};
      return {d1_csb, d1_sclk, d1_mosi, d1_busy, d1_done};
   endfunction

   // Expected pins k cycles after the acceptance edge, from the frame timing rules.
   function automatic logic [4:0] model(int h, int len, logic [73:0] data, int k);
      int nb = h * (2 * len + 2);
      int nc = h * (2 * len + 1);
      int p  = k / h;
      int b;
      logic csb, sclk, mosi;
      if (k >= nb) return {1'b1, 1'b0, 1'b0, 1'b0, (k == nb)};
      csb  = (k < nc) ? 1'b0 : 1'b1;
      sclk = (p >= 1) && (p <= 2 * len - 1) && (p % 2 == 1);
      mosi = 1'b0;
      if (!csb) begin
         b = p / 2;
         if (b > len - 1) b = len - 1;
         mosi = data[len - 1 - b];
      end
      return {csb, sclk, mosi, 1'b1, 1'b0};
   endfunction

   task automatic check(string name, logic [4:0] act, logic [4:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got csb/sclk/mosi/busy/done=%b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_word(string name, logic [73:0] act, logic [73:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Entered and left on a negedge; checks n cycles of idle pins.
   task automatic idle_check(int d, int n, string tag);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s idle d%0d c%0d", tag, d, i), get_out(d), IDLE_OUT);
         @(negedge clk);
      end
   endtask

   task automatic reject_frame(int d, int len);
      st[d] = 1'b1;
      ln[d] = 7'(len);
      dt[d] = 74'({$urandom(), $urandom(), $urandom()});
      @(negedge clk);
      st[d] = 1'b0;
      idle_check(d, 12, $sformatf("reject len%0d", len));
   endtask

   // mode 0: normal frame; 1: abort at cycle at_k; 2: async reset at cycle at_k.
   task automatic run_frame(int d, int len, logic [73:0] data, int mode, int at_k);
      int          h = half_of(d);
      int          nb = h * (2 * len + 2);
      int          ncsb = 0, nrise = 0, nbusy = 0, ndone = 0;
      logic        prev_sclk = 1'b0;
      logic [73:0] rec = '0;
      logic [73:0] msk;
      logic [4:0]  o;
      string       nm;
      st[d] = 1'b1;
      ln[d] = 7'(len);
      dt[d] = data;
      ab[d] = 1'b0;
      @(negedge clk);
      st[d] = 1'b0;
      ln[d] = 7'($urandom_range(0, 127));
      dt[d] = 74'({$urandom(), $urandom(), $urandom()});
      for (int k = 0; k <= nb; k++) begin
         o = get_out(d);
         nm = $sformatf("frame d%0d len%0d k%0d", d, len, k);
         check(nm, o, model(h, len, data, k));
         if (!o[4]) ncsb++;
         if (o[3] && !prev_sclk) begin
            rec = {rec[72:0], o[2]};
            nrise++;
         end
         prev_sclk = o[3];
         if (o[1]) nbusy++;
         if (o[0]) ndone++;
         if (mode == 1 && k == at_k) begin
            ab[d] = 1'b1;
            @(negedge clk);
            ab[d] = 1'b0;
            check("abort next cycle", get_out(d), IDLE_OUT);
            @(negedge clk);
            idle_check(d, nb, "after abort");
            return;
         end
         if (mode == 2 && k == at_k) begin
            #1 reset = 1'b1;
            #1 check("async reset immediate", get_out(d), IDLE_OUT);
            @(negedge clk);
            reset = 1'b0;
            idle_check(d, nb, "after reset");
            return;
         end
         @(negedge clk);
      end
      check($sformatf("done clears d%0d len%0d", d, len), get_out(d), IDLE_OUT);
      check_int($sformatf("csb low cycles d%0d len%0d", d, len), ncsb, h * (2 * len + 1));
      check_int($sformatf("sclk pulses d%0d len%0d", d, len), nrise, len);
      check_int($sformatf("busy cycles d%0d len%0d", d, len), nbusy, h * (2 * len + 2));
      check_int($sformatf("done pulses d%0d len%0d", d, len), ndone, 1);
      msk = (len >= FW) ? '1 : ((74'(1) << len) - 74'(1));
      check_word($sformatf("sniffed bits d%0d len%0d", d, len), rec, data & msk);
   endtask

   // Start held high, HALF=2, len=2: three back-to-back frames.
   task automatic back_to_back();
      int          period = 2 * (2 * 2 + 2) + 1;
      logic [73:0] data = 74'b10;
      logic [4:0]  o;
      int          gap_high = 0, ndone = 0;
      st[1] = 1'b1;
      ln[1] = 7'd2;
      dt[1] = data;
      @(negedge clk);
      for (int t = 0; t < 3 * period; t++) begin
         o = get_out(1);
         check($sformatf("b2b t%0d", t), o, model(2, 2, data, t % period));
         if (t < period && o[4]) gap_high++;
         if (o[0]) ndone++;
         if (t == 3 * period - 1) st[1] = 1'b0;
         @(negedge clk);
      end
      check_int("b2b csb high gap", gap_high, 3);
      check_int("b2b done pulses", ndone, 3);
      idle_check(1, 6, "b2b end");
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         st[d] = 1'b0;
         ab[d] = 1'b0;
         ln[d] = '0;
         dt[d] = '0;
      end
      reset = 1'b1;
      @(negedge clk);
      check("reset d0", get_out(0), IDLE_OUT);
      check("reset d1", get_out(1), IDLE_OUT);
      reset = 1'b0;
      @(negedge clk);
      check("post reset d0", get_out(0), IDLE_OUT);
      check("post reset d1", get_out(1), IDLE_OUT);

      tbl[0] = '{d: 1, len: 3,  data: 74'b101, ok: 1'b1};
      tbl[1] = '{d: 0, len: 74, data: 74'({$urandom(), $urandom(), $urandom()}), ok: 1'b1};
      tbl[2] = '{d: 1, len: 0,  data: '1, ok: 1'b0};
      tbl[3] = '{d: 1, len: 75, data: '1, ok: 1'b0};
      tbl[4] = '{d: 0, len: 0,  data: '1, ok: 1'b0};
      tbl[5] = '{d: 0, len: 75, data: '1, ok: 1'b0};
      tbl[6] = '{d: 0, len: 1,  data: 74'b1, ok: 1'b1};
      tbl[7] = '{d: 1, len: 1,  data: 74'b0, ok: 1'b1};
      tbl[8] = '{d: 1, len: 74, data: 74'({$urandom(), $urandom(), $urandom()}), ok: 1'b1};
      tbl[9] = '{d: 0, len: 2,  data: 74'b01, ok: 1'b1};

      foreach (tbl[i]) begin
         if (tbl[i].ok) run_frame(tbl[i].d, tbl[i].len, tbl[i].data, 0, 0);
         else           reject_frame(tbl[i].d, tbl[i].len);
      end

      for (int r = 0; r < 16; r++) begin
         run_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, FW)),
                   74'({$urandom(), $urandom(), $urandom()}), 0, 0);
      end

      // Abort during the third HIGH phase (HALF=2: phase 5 starts at cycle 10).
      run_frame(1, 5, 74'b10110, 1, 10);
      run_frame(1, 4, 74'b1001, 0, 0);

      // Asynchronous reset during the first LOW phase (cycle 4 with HALF=2).
      run_frame(1, 5, 74'b11010, 2, 4);
      run_frame(1, 3, 74'b101, 0, 0);

      back_to_back();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
